// File: rtl/branch_pc_ctrl_if.sv
// ============================================================================
//  Module      : branch_pc_ctrl_if
//  Description : Request/status bundle between the control unit and the
//                branch/PC controller. BRANCH_STATS_EN adds the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface branch_pc_ctrl_if;
    logic        start;
    logic        seq_inc;
    logic [31:0] ir;
    logic        con_in;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;

    modport master (output start, seq_inc, ir, con_in,
                    input  pc, busy, done, taken, taken_cnt, not_taken_cnt);
    modport slave  (input  start, seq_inc, ir, con_in,
                    output pc, busy, done, taken, taken_cnt, not_taken_cnt);
`else
    modport master (output start, seq_inc, ir, con_in,
                    input  pc, busy, done, taken);
    modport slave  (input  start, seq_inc, ir, con_in,
                    output pc, busy, done, taken);
`endif
endinterface

`default_nettype wire

// File: rtl/branch_pc_ctrl.sv
// ============================================================================
//  Module      : branch_pc_ctrl
//  Description : Program counter owner; increments on fetch and resolves
//                conditional branches (PC <= PC + SE(C) when CON is set).
//                Optional macro BRANCH_STATS_EN adds taken/not-taken counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module branch_pc_ctrl #(
    parameter logic [4:0]  BR_OPCODE = 5'b10010,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       clr,
    branch_pc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] target_q, target_d;
    logic        con_ff_q, con_ff_d;
    logic        taken_q, taken_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] not_taken_cnt_q, not_taken_cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        target_d = target_q;
        con_ff_d = con_ff_q;
        taken_d  = taken_q;
`ifdef BRANCH_STATS_EN
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // start has priority over a same-cycle fetch increment
                if (bus.start) begin
                    ir_d    = bus.ir;
                    taken_d = 1'b0;
                    if (bus.ir[31:27] == BR_OPCODE) begin
                        state_d = EVAL;
                    end else begin
                        state_d  = FIN;
                        con_ff_d = 1'b0;
                    end
                end else if (bus.seq_inc) begin
                    pc_d = pc_q + 32'd1;
                end
            end
            EVAL: begin
                con_ff_d = bus.con_in;
                state_d  = CALC;
            end
            CALC: begin
                target_d = pc_q + {{13{ir_q[18]}}, ir_q[18:0]};
                state_d  = FIN;
            end
            FIN: begin
                taken_d = con_ff_q;
                if (con_ff_q) begin
                    pc_d = target_q;
                end
`ifdef BRANCH_STATS_EN
                // non-branch instructions also pass through FIN but are not counted
                if (ir_q[31:27] == BR_OPCODE) begin
                    if (con_ff_q) begin
                        if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
                    end else begin
                        if (not_taken_cnt_q != 16'hFFFF) not_taken_cnt_d = not_taken_cnt_q + 16'd1;
                    end
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            target_q <= 32'd0;
            con_ff_q <= 1'b0;
            taken_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BRANCH_STATS_EN
            taken_cnt_q     <= 16'd0;
            not_taken_cnt_q <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            target_q <= target_d;
            con_ff_q <= con_ff_d;
            taken_q  <= taken_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BRANCH_STATS_EN
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
`endif
        end
    end

    assign bus.pc    = pc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.taken = taken_q;
`ifdef BRANCH_STATS_EN
    assign bus.taken_cnt     = taken_cnt_q;
    assign bus.not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_ctrl.sv
// ============================================================================
//  Module      : tb_branch_pc_ctrl
//  Description : Directed self-checking bench for branch_pc_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_branch_pc_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    branch_pc_ctrl_if bus_if ();

    branch_pc_ctrl #(
        .BR_OPCODE (5'b10010),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        clr = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.seq_inc = 1'b0;
        bus_if.ir      = 32'd0;
        bus_if.con_in  = 1'b0;
        tick();
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic inc_n(input int n);
        bus_if.seq_inc = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus_if.seq_inc = 1'b0;
    endtask

    // Issues one branch; con_in is the requested value only during EVAL and
    // its inverse elsewhere, and ir is scrambled after the start edge.
    task automatic drive_branch(input logic [31:0] ir_v, input logic con_v,
                                output logic [2:0] done_seen);
        bus_if.ir     = ir_v;
        bus_if.start  = 1'b1;
        bus_if.con_in = ~con_v;
        tick();
        bus_if.start  = 1'b0;
        bus_if.ir     = 32'h0000_0000;
        bus_if.con_in = con_v;
        done_seen[0]  = bus_if.done;
        tick();
        bus_if.con_in = ~con_v;
        done_seen[1]  = bus_if.done;
        tick();
        done_seen[2]  = bus_if.done;
        tick();
        bus_if.con_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (bus_if.pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus_if.pc, 32'd0); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
        checks++; if (bus_if.taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", bus_if.taken); end
        inc_n(3);
        checks++; if (bus_if.pc !== 32'd3) begin failures++; $display("FAIL seq_inc3 got=%h exp=%h", bus_if.pc, 32'd3); end
    endtask

    task automatic test_taken();
        logic [2:0] d;
        inc_n(13);
        checks++; if (bus_if.pc !== 32'h10) begin failures++; $display("FAIL pc_setup got=%h exp=%h", bus_if.pc, 32'h10); end
        drive_branch(32'h9080_0005, 1'b1, d);
        checks++; if (d !== 3'b100) begin failures++; $display("FAIL taken_done_timing got=%b exp=100", d); end
        checks++; if (bus_if.pc !== 32'h15) begin failures++; $display("FAIL taken_pc got=%h exp=%h", bus_if.pc, 32'h15); end
        checks++; if (bus_if.taken !== 1'b1) begin failures++; $display("FAIL taken_flag got=%b exp=1", bus_if.taken); end
        checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin failures++; $display("FAIL taken_idle busy=%b done=%b exp=0 0", bus_if.busy, bus_if.done); end
    endtask

    task automatic test_not_taken_neg();
        logic [2:0] d;
        reset_dut();
        inc_n(16);
        drive_branch(32'h9087_FFFC, 1'b0, d);
        checks++; if (d !== 3'b100) begin failures++; $display("FAIL nt_done_timing got=%b exp=100", d); end
        checks++; if (bus_if.pc !== 32'h10) begin failures++; $display("FAIL nt_pc got=%h exp=%h", bus_if.pc, 32'h10); end
        checks++; if (bus_if.taken !== 1'b0) begin failures++; $display("FAIL nt_flag got=%b exp=0", bus_if.taken); end
        drive_branch(32'h9087_FFFC, 1'b1, d);
        checks++; if (bus_if.pc !== 32'h0C) begin failures++; $display("FAIL neg_pc got=%h exp=%h", bus_if.pc, 32'h0C); end
        checks++; if (bus_if.taken !== 1'b1) begin failures++; $display("FAIL neg_flag got=%b exp=1", bus_if.taken); end
    endtask

    task automatic test_non_branch();
        logic d;
        bus_if.ir      = 32'h1880_0005;
        bus_if.start   = 1'b1;
        bus_if.seq_inc = 1'b1;
        bus_if.con_in  = 1'b1;
        tick();
        bus_if.start   = 1'b0;
        checks++; if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b1) begin failures++; $display("FAIL nb_done_n1 done=%b busy=%b exp=1 1", bus_if.done, bus_if.busy); end
        checks++; if (bus_if.taken !== 1'b0) begin failures++; $display("FAIL nb_taken_cleared got=%b exp=0", bus_if.taken); end
        tick();
        bus_if.seq_inc = 1'b0;
        checks++; if (bus_if.pc !== 32'h0C) begin failures++; $display("FAIL nb_pc got=%h exp=%h", bus_if.pc, 32'h0C); end
        checks++; if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.taken !== 1'b0) begin failures++; $display("FAIL nb_after done=%b busy=%b taken=%b exp=0 0 0", bus_if.done, bus_if.busy, bus_if.taken); end
        // start and seq_inc held high for the whole branch must not be seen
        bus_if.ir      = 32'h9080_0005;
        bus_if.start   = 1'b1;
        bus_if.seq_inc = 1'b1;
        tick();
        bus_if.con_in  = 1'b0;
        tick();
        bus_if.con_in  = 1'b1;
        tick();
        d = bus_if.done;
        tick();
        bus_if.start   = 1'b0;
        bus_if.seq_inc = 1'b0;
        bus_if.con_in  = 1'b0;
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL busy_ign_done got=%b exp=1", d); end
        checks++; if (bus_if.pc !== 32'h0C || bus_if.busy !== 1'b0) begin failures++; $display("FAIL busy_ign_pc pc=%h busy=%b exp=0000000c 0", bus_if.pc, bus_if.busy); end
        tick();
        checks++; if (bus_if.pc !== 32'h0C || bus_if.taken !== 1'b0) begin failures++; $display("FAIL taken_hold pc=%h taken=%b exp=0000000c 0", bus_if.pc, bus_if.taken); end
`ifdef BRANCH_STATS_EN
        checks++; if (bus_if.taken_cnt !== 16'd1) begin failures++; $display("FAIL stat_taken got=%0d exp=1", bus_if.taken_cnt); end
        checks++; if (bus_if.not_taken_cnt !== 16'd2) begin failures++; $display("FAIL stat_not_taken got=%0d exp=2", bus_if.not_taken_cnt); end
`endif
    endtask

    task automatic test_wrap();
        logic [2:0] d;
        reset_dut();
        drive_branch(32'h9007_FFFF, 1'b1, d);
        checks++; if (bus_if.pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_neg1 got=%h exp=ffffffff", bus_if.pc); end
        inc_n(1);
        checks++; if (bus_if.pc !== 32'd0) begin failures++; $display("FAIL wrap_inc got=%h exp=00000000", bus_if.pc); end
        drive_branch(32'h9007_FFFE, 1'b1, d);
        checks++; if (bus_if.pc !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_neg2 got=%h exp=fffffffe", bus_if.pc); end
        drive_branch(32'h9000_0003, 1'b1, d);
        checks++; if (bus_if.pc !== 32'h0000_0001) begin failures++; $display("FAIL wrap_add got=%h exp=00000001", bus_if.pc); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus_if.ir     = 32'h9080_0005;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start  = 1'b0;
        bus_if.con_in = 1'b1;
        tick();
        checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL mid_in_calc busy=%b exp=1", bus_if.busy); end
        clr = 1'b1;
        #2;
        checks++; if (bus_if.pc !== 32'd0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL mid_async pc=%h busy=%b exp=00000000 0", bus_if.pc, bus_if.busy); end
`ifdef BRANCH_STATS_EN
        checks++; if (bus_if.taken_cnt !== 16'd0 || bus_if.not_taken_cnt !== 16'd0) begin failures++; $display("FAIL mid_stats t=%0d nt=%0d exp=0 0", bus_if.taken_cnt, bus_if.not_taken_cnt); end
`endif
        seen = 1'b0;
        tick();
        clr = 1'b0;
        bus_if.con_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_if.done !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%b exp=0", seen); end
        checks++; if (bus_if.pc !== 32'd0 || bus_if.taken !== 1'b0) begin failures++; $display("FAIL mid_after pc=%h taken=%b exp=00000000 0", bus_if.pc, bus_if.taken); end
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.seq_inc = 1'b0;
        bus_if.ir      = 32'd0;
        bus_if.con_in  = 1'b0;
        test_reset();
        test_taken();
        test_not_taken_neg();
        test_non_branch();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
